// File: rtl/cci_mpf_shim_edge_pkg.sv
// Shared types and helpers for the MPF edge write-data heap.
package cci_mpf_shim_edge_pkg;

   localparam int DEF_N_ENTRIES = 128;
   localparam int DEF_N_LINES   = 4;

   typedef logic [$clog2(DEF_N_ENTRIES)-1:0] t_heap_idx;
   typedef logic [$clog2(DEF_N_LINES)-1:0]   t_heap_clnum;
   typedef logic [$clog2(DEF_N_ENTRIES):0]   t_heap_cnt;

   typedef enum logic {
      IDLE,
      IN_PKT
   } t_wdata_fsm;

   // Flat RAM address: slot index in the upper bits, line number below it.
   function automatic logic [31:0] heap_addr(input logic [31:0] idx,
                                             input logic [31:0] clnum,
                                             input int          clnum_w);
      return (idx << clnum_w) | clnum;
   endfunction

endpackage

// File: rtl/cci_mpf_shim_edge_heap_ram.sv
// Simple dual-port heap RAM: synchronous array read then output register (2-cycle read).
module cci_mpf_shim_edge_heap_ram #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 512
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] q_p1;
   logic              vld_p1;

   // Stage 1: array read samples pre-write contents on a same-cycle collision
   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
      if (rd_en) q_p1 <= mem[raddr];
   end

   // Stage 2: output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1 <= 1'b0;
         q      <= '0;
      end else begin
         vld_p1 <= rd_en;
         if (vld_p1) q <= q_p1;
      end
   end

endmodule

// File: rtl/cci_mpf_shim_edge_wdata_heap.sv
// FIU-side write-data heap: stores packet lines by slot, serves reads, returns freed slots.
// Optional same/previous-cycle write forwarding: CCI_MPF_EDGE_WDATA_HEAP_BYPASS_EN.
module cci_mpf_shim_edge_wdata_heap
   import cci_mpf_shim_edge_pkg::*;
#(
   parameter int N_WRITE_HEAP_ENTRIES = DEF_N_ENTRIES,
   parameter int N_LINES_PER_ENTRY    = DEF_N_LINES,
   parameter int ALM_FULL_THRESH      = 8,
   parameter int CL_DATA_WIDTH        = 512,
   localparam int IDX_W = $clog2(N_WRITE_HEAP_ENTRIES),
   localparam int CL_W  = $clog2(N_LINES_PER_ENTRY)
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wen,
   input  logic [IDX_W-1:0]         widx,
   input  logic                     wsop,
   input  logic                     weop,
   input  logic [CL_W-1:0]          wclnum,
   input  logic [CL_DATA_WIDTH-1:0] wdata,
   output logic                     wAlmFull,
   input  logic                     rd_en,
   input  logic [IDX_W-1:0]         rd_idx,
   input  logic [CL_W-1:0]          rd_clnum,
   output logic                     rd_valid,
   output logic [CL_DATA_WIDTH-1:0] rd_data,
   input  logic                     rel_en,
   input  logic [IDX_W-1:0]         rel_idx,
   output logic                     free,
   output logic [IDX_W-1:0]         freeidx,
   output logic                     err
);

   localparam int ADDR_W = IDX_W + CL_W;
   localparam int CNT_W  = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_WRITE_HEAP_ENTRIES);
   localparam logic [CNT_W-1:0] ALM_LVL = CNT_W'(N_WRITE_HEAP_ENTRIES - ALM_FULL_THRESH);

   logic [ADDR_W-1:0]        waddr, raddr;
   logic [CL_DATA_WIDTH-1:0] ram_q;
   logic [CNT_W-1:0]         occ_cnt, cnt_nxt;
   logic                     cnt_err, proto_err;
   t_wdata_fsm               state;
   logic [IDX_W-1:0]         pkt_idx;
   logic [CL_W-1:0]          last_cl;
   logic                     vld_p1, vld_p2;

   assign waddr = ADDR_W'(heap_addr(32'(widx), 32'(wclnum), CL_W));
   assign raddr = ADDR_W'(heap_addr(32'(rd_idx), 32'(rd_clnum), CL_W));

   cci_mpf_shim_edge_heap_ram #(
      .DEPTH  (N_WRITE_HEAP_ENTRIES * N_LINES_PER_ENTRY),
      .ADDR_W (ADDR_W),
      .DATA_W (CL_DATA_WIDTH)
   ) heap_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wen     (wen),
      .waddr   (waddr),
      .wdata   (wdata),
      .rd_en   (rd_en),
      .raddr   (raddr),
      .q       (ram_q)
   );

   // Simultaneous allocate and release cancel; lone ops at a limit hold and flag
   always_comb begin
      cnt_nxt = occ_cnt;
      cnt_err = 1'b0;
      if (wen && wsop && !rel_en) begin
         if (occ_cnt == CNT_MAX) cnt_err = 1'b1;
         else                    cnt_nxt = occ_cnt + 1'b1;
      end else if (rel_en && !(wen && wsop)) begin
         if (occ_cnt == '0) cnt_err = 1'b1;
         else               cnt_nxt = occ_cnt - 1'b1;
      end
   end

   always_comb begin
      proto_err = 1'b0;
      if (wen) begin
         if (state == IDLE) begin
            proto_err = !wsop;
         end else begin
            proto_err = wsop || (widx != pkt_idx) ||
                        (wclnum != CL_W'(last_cl + 1'b1));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_cnt  <= '0;
         wAlmFull <= 1'b0;
         free     <= 1'b0;
         freeidx  <= '0;
      end else begin
         occ_cnt  <= cnt_nxt;
         wAlmFull <= (cnt_nxt >= ALM_LVL);
         free     <= rel_en;
         if (rel_en) freeidx <= rel_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         pkt_idx <= '0;
         last_cl <= '0;
         err     <= 1'b0;
      end else begin
         if (proto_err || cnt_err) err <= 1'b1;
         if (wen) begin
            last_cl <= wclnum;
            case (state)
               IDLE: begin
                  if (wsop && !weop) begin
                     state   <= IN_PKT;
                     pkt_idx <= widx;
                  end
               end
               IN_PKT: begin
                  if (weop) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Read valid pipeline p1 -> p2 matches the RAM's two register stages
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         vld_p2 <= vld_p1;
      end
   end

   assign rd_valid = vld_p2;

`ifdef CCI_MPF_EDGE_WDATA_HEAP_BYPASS_EN
   // A previous-cycle write is already visible to the array read, so only
   // the same-cycle collision needs forwarding.
   logic                     fwd_hit_p1, fwd_hit_p2;
   logic [CL_DATA_WIDTH-1:0] fwd_data_p1, fwd_data_p2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_hit_p1 <= 1'b0;
         fwd_hit_p2 <= 1'b0;
      end else begin
         fwd_hit_p1 <= rd_en && wen && (raddr == waddr);
         fwd_hit_p2 <= fwd_hit_p1;
      end
   end

   always_ff @(posedge clk) begin
      fwd_data_p1 <= wdata;
      fwd_data_p2 <= fwd_data_p1;
   end

   assign rd_data = fwd_hit_p2 ? fwd_data_p2 : ram_q;
`else
   assign rd_data = ram_q;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_edge_wdata_heap.sv
// Directed plus randomized bench for the edge write-data heap with a slot-level reference model.
module tb_cci_mpf_shim_edge_wdata_heap;

   localparam int N  = 128;
   localparam int L  = 4;
   localparam int TH = 8;
   localparam int W  = 512;
   localparam int IW = 7;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wen, wsop, weop;
   logic [IW-1:0] widx;
   logic [CW-1:0] wclnum;
   logic [W-1:0]  wdata;
   logic          wAlmFull;
   logic          rd_en;
   logic [IW-1:0] rd_idx;
   logic [CW-1:0] rd_clnum;
   logic          rd_valid;
   logic [W-1:0]  rd_data;
   logic          rel_en;
   logic [IW-1:0] rel_idx;
   logic          free;
   logic [IW-1:0] freeidx;
   logic          err;

   always #5 clk = ~clk;

   cci_mpf_shim_edge_wdata_heap #(
      .N_WRITE_HEAP_ENTRIES (N),
      .N_LINES_PER_ENTRY    (L),
      .ALM_FULL_THRESH      (TH),
      .CL_DATA_WIDTH        (W)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wen      (wen),
      .widx     (widx),
      .wsop     (wsop),
      .weop     (weop),
      .wclnum   (wclnum),
      .wdata    (wdata),
      .wAlmFull (wAlmFull),
      .rd_en    (rd_en),
      .rd_idx   (rd_idx),
      .rd_clnum (rd_clnum),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rel_en   (rel_en),
      .rel_idx  (rel_idx),
      .free     (free),
      .freeidx  (freeidx),
      .err      (err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: line storage, slot occupancy and packet rules
   typedef struct {
      int         due;
      logic [W-1:0] d;
   } rd_t;

   logic [W-1:0]  mmem [N*L];
   bit            mknown [N*L];
   int            mcnt;
   bit            merr, malm, mfree, minpkt;
   logic [IW-1:0] mfreeidx;
   int            mpidx, mlastcl;
   int            cyc = 0;
   rd_t           rq[$];

   function automatic logic [W-1:0] rnd_line();
      logic [W-1:0] v;
      for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mcnt = 0; merr = 0; malm = 0; mfree = 0; mfreeidx = '0;
      minpkt = 0; mpidx = 0; mlastcl = 0;
      rq.delete();
   endtask

   task automatic model_step();
      int           wa, ra;
      bit           inc;
      logic [W-1:0] d;
      wa  = int'(widx) * L + int'(wclnum);
      ra  = int'(rd_idx) * L + int'(rd_clnum);
      inc = wen && wsop;
      if (rd_en) begin
         d = mmem[ra];
`ifdef CCI_MPF_EDGE_WDATA_HEAP_BYPASS_EN
         if (wen && wa == ra) d = wdata;
`endif
         rq.push_back('{due: cyc + 2, d: d});
      end
      if (wen) begin
         mmem[wa]   = wdata;
         mknown[wa] = 1;
         if (!minpkt) begin
            if (!wsop) merr = 1;
            else if (!weop) begin minpkt = 1; mpidx = int'(widx); end
         end else begin
            if (wsop || int'(widx) != mpidx || int'(wclnum) != (mlastcl + 1) % L) merr = 1;
            if (weop) minpkt = 0;
         end
         mlastcl = int'(wclnum);
      end
      if (inc && !rel_en) begin
         if (mcnt == N) merr = 1; else mcnt++;
      end else if (rel_en && !inc) begin
         if (mcnt == 0) merr = 1; else mcnt--;
      end
      malm  = (mcnt >= N - TH);
      mfree = rel_en;
      if (rel_en) mfreeidx = rel_idx;
   endtask

   task automatic check_outputs(input string tag);
      bit           ev;
      logic [W-1:0] ed;
      ev = 0; ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ev = 1; ed = rq[0].d;
         void'(rq.pop_front());
      end
      check({tag, " rd_valid"}, W'(rd_valid), W'(ev));
      if (ev) check({tag, " rd_data"}, rd_data, ed);
      check({tag, " wAlmFull"}, W'(wAlmFull), W'(malm));
      check({tag, " err"}, W'(err), W'(merr));
      check({tag, " free"}, W'(free), W'(mfree));
      check({tag, " freeidx"}, W'(freeidx), W'(mfreeidx));
      check({tag, " count"}, W'(dut.occ_cnt), W'(mcnt));
   endtask

   task automatic idle_inputs();
      wen = 0; wsop = 0; weop = 0; widx = '0; wclnum = '0; wdata = '0;
      rd_en = 0; rd_idx = '0; rd_clnum = '0; rel_en = 0; rel_idx = '0;
   endtask

   task automatic wr(input int idx, input int cl, input bit sop, input bit eop, input logic [W-1:0] d);
      wen = 1; widx = IW'(idx); wclnum = CW'(cl); wsop = sop; weop = eop; wdata = d;
   endtask

   task automatic rd(input int idx, input int cl);
      rd_en = 1; rd_idx = IW'(idx); rd_clnum = CW'(cl);
   endtask

   task automatic rel(input int idx);
      rel_en = 1; rel_idx = IW'(idx);
   endtask

   task automatic step(input string tag);
      if (reset_n) model_step();
      @(posedge clk); #1;
      cyc++;
      idle_inputs();
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      idle_inputs();
      reset_n = 0;
      #1;
      model_reset();
      check_outputs(tag);
      check({tag, " rd_data"}, rd_data, '0);
      step({tag, " hold0"});
      step({tag, " hold1"});
      reset_n = 1;
   endtask

   logic [W-1:0] line [L];
   logic [W-1:0] old_v, new_v;
   bit           used [N];
   bit           done [N];
   bit           act;
   int           pidx, pcl, plen, t, ra;

   initial begin
      reset_n = 0;
      idle_inputs();
      model_reset();
      do_reset("reset");

      // Single-line packet, read back two cycles later
      wr(5, 0, 1, 1, {64{8'hA5}}); step("sl_wr");
      step("sl_gap");
      rd(5, 0); step("sl_rd");
      step("sl_rd_lat");
      check("sl_data", rd_data, {64{8'hA5}});
      check("sl_count", W'(dut.occ_cnt), W'(1));

      // Four-line packet, read the last line, release both slots back to back
      for (int cl = 0; cl < L; cl++) begin
         line[cl] = rnd_line();
         wr(9, cl, cl == 0, cl == L-1, line[cl]); step("ml_wr");
      end
      check("ml_err", W'(err), W'(0));
      rd(9, 3); step("ml_rd");
      step("ml_rd_lat");
      check("ml_cl3", rd_data, line[3]);
      rel(9); step("rel9");
      check("rel9_free", W'(free), W'(1));
      check("rel9_idx", W'(freeidx), W'(9));
      rel(5); step("rel5");
      check("rel5_free", W'(free), W'(1));
      check("rel5_idx", W'(freeidx), W'(5));
      step("rel_done");
      check("rel_free_low", W'(free), W'(0));
      check("rel_count", W'(dut.occ_cnt), W'(0));

      // Randomized legal traffic: packets, reads of known lines, releases
      act = 0;
      for (int c = 0; c < 300 || act; c++) begin
         if (act) begin
            wr(pidx, pcl, 0, pcl == plen-1, rnd_line());
            pcl++;
            if (pcl == plen) begin act = 0; done[pidx] = 1; end
         end else if ($urandom_range(0, 2) == 0 && mcnt < 100) begin
            t = $urandom_range(0, N-1);
            if (!used[t]) begin
               used[t] = 1; pidx = t; plen = $urandom_range(1, L);
               wr(t, 0, 1, plen == 1, rnd_line());
               pcl = 1;
               if (plen == 1) done[t] = 1; else act = 1;
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            ra = $urandom_range(0, N*L-1);
            if (wen && $urandom_range(0, 3) == 0) ra = int'(widx) * L + int'(wclnum);
            if (mknown[ra]) rd(ra / L, ra % L);
         end
         if ($urandom_range(0, 3) == 0) begin
            t = $urandom_range(0, N-1);
            if (done[t]) begin rel(t); done[t] = 0; used[t] = 0; end
         end
         step("rnd");
      end
      for (int i = 0; i < N; i++) begin
         if (done[i]) begin rel(i); done[i] = 0; used[i] = 0; step("rnd_drain"); end
      end
      step("rnd_flush0");
      step("rnd_flush1");
      check("rnd_count", W'(dut.occ_cnt), W'(0));

      // Fill to the almost-full level and back off
      for (int i = 0; i < N - TH; i++) begin
         wr(i, 0, 1, 1, rnd_line()); step("fill");
         if (i == N - TH - 2) check("alm_below", W'(wAlmFull), W'(0));
      end
      check("alm_set", W'(wAlmFull), W'(1));
      rel(0); step("alm_rel");
      check("alm_clear", W'(wAlmFull), W'(0));
      wr(0, 0, 1, 1, rnd_line()); rel(1); step("alloc_rel");
      check("alloc_rel_count", W'(dut.occ_cnt), W'(N - TH - 1));

      // Overflow
      wr(1, 0, 1, 1, rnd_line()); step("fill_top");
      for (int i = N - TH; i < N; i++) begin
         wr(i, 0, 1, 1, rnd_line()); step("fill_top");
      end
      check("full_count", W'(dut.occ_cnt), W'(N));
      check("full_no_err", W'(err), W'(0));
      wr(5, 0, 1, 1, rnd_line()); step("ovf");
      check("ovf_err", W'(err), W'(1));
      check("ovf_count", W'(dut.occ_cnt), W'(N));
      do_reset("ovf_rst");
      check("ovf_rst_err", W'(err), W'(0));

      // Protocol violations
      wr(2, 0, 1, 0, rnd_line()); step("skip_a");
      wr(2, 2, 0, 1, rnd_line()); step("skip_b");
      check("skip_err", W'(err), W'(1));
      do_reset("skip_rst");
      wr(4, 0, 1, 0, rnd_line()); step("dsop_a");
      wr(4, 1, 1, 0, rnd_line()); step("dsop_b");
      check("dsop_err", W'(err), W'(1));
      do_reset("dsop_rst");
      wr(6, 0, 1, 0, rnd_line()); step("idx_a");
      wr(7, 1, 0, 1, rnd_line()); step("idx_b");
      check("idx_err", W'(err), W'(1));
      do_reset("idx_rst");

      // Reset while a read is in flight
      rd(9, 3); step("mid_rd");
      do_reset("mid_rd_rst");

      // Same-cycle and previous-cycle write/read collisions
      old_v = {64{8'h11}};
      new_v = {64{8'h77}};
      wr(3, 1, 1, 1, old_v); step("byp_old");
      step("byp_gap0");
      step("byp_gap1");
      wr(3, 1, 1, 1, new_v); rd(3, 1); step("byp_same");
      step("byp_same_lat");
`ifdef CCI_MPF_EDGE_WDATA_HEAP_BYPASS_EN
      check("byp_same_data", rd_data, new_v);
`else
      check("byp_same_data", rd_data, old_v);
`endif
      wr(3, 1, 1, 1, {64{8'h3C}}); step("byp_prev_wr");
      rd(3, 1); step("byp_prev_rd");
      step("byp_prev_lat");
      check("byp_prev_data", rd_data, {64{8'h3C}});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cci_mpf_shim_edge_wdata_heap.md
Name: cci_mpf_shim_edge_wdata_heap

Overview:
- FIU-side write-data heap: the consumer of the AFU edge write-data bypass channel.
- Captures multi-line write payloads by heap index and serves them to the FIU edge when the matching write header issues.
- Returns freed indices to the AFU edge.
- Drives back-pressure (wAlmFull) upstream so the AFU edge stops allocating before the heap overflows.

Parameters:
- N_WRITE_HEAP_ENTRIES, 128: heap slots; power of 2, minimum 4.
- N_LINES_PER_ENTRY, 4: cache lines per slot; addressed by wclnum.
- ALM_FULL_THRESH, 8: wAlmFull asserts when free slots are at or below this value; must be less than N_WRITE_HEAP_ENTRIES.
- CL_DATA_WIDTH, 512: line width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wen  in  1  write a line into the heap
- widx  in  log2(N_WRITE_HEAP_ENTRIES)  slot index
- wsop  in  1  first line of the slot's packet; allocates the slot
- weop  in  1  last line of the packet
- wclnum  in  log2(N_LINES_PER_ENTRY)  line within slot
- wdata  in  CL_DATA_WIDTH  line data
- wAlmFull  out  1  almost-full to the AFU edge
- rd_en  in  1  FIU edge read request
- rd_idx  in  log2(N_WRITE_HEAP_ENTRIES)  slot to read
- rd_clnum  in  log2(N_LINES_PER_ENTRY)  line to read
- rd_valid  out  1  rd_data valid
- rd_data  out  CL_DATA_WIDTH  read data
- rel_en  in  1  FIU edge finished with slot rel_idx
- rel_idx  in  log2(N_WRITE_HEAP_ENTRIES)  slot released
- free  out  1  slot-freed pulse to the AFU edge
- freeidx  out  log2(N_WRITE_HEAP_ENTRIES)  freed slot index
- err  out  1  sticky protocol/overflow error

Behaviour:
- Reset (reset_n low, asynchronous):
  - Occupancy count = 0; FSM = IDLE.
  - Outputs: wAlmFull=0, rd_valid=0, free=0, freeidx=0, err=0, rd_data=0.
  - RAM contents are not reset.
  - Reset asserted mid-packet or mid-read discards all state; an in-flight rd_valid is suppressed.
- Storage: each line is written to RAM address {widx, wclnum} on the cycle wen=1.
- Occupancy counter: width log2(N)+1. Increments on wen&wsop; decrements on rel_en.
  - Both in the same cycle: count unchanged.
  - Saturates at 0 and at N.
  - Allocation when count==N sets err and the count holds.
  - Release when count==0 sets err and the count holds.
- wAlmFull: registered; asserts the cycle after the count reaches N-ALM_FULL_THRESH or more. Deasserts the cycle after the count drops below that value.
- Packet FSM, states IDLE and IN_PKT:
  - IDLE: wen&wsop&weop stays in IDLE (1-line packet); wen&wsop&!weop goes to IN_PKT and latches widx.
  - IN_PKT: wen&weop returns to IDLE.
  - The following set err: wen&wsop while in IN_PKT; wen&!wsop while in IDLE; widx differing from the latched index; wclnum not equal to the previous wclnum+1.
  - On error the FSM still follows weop.
- Read path: fixed 2-cycle latency. rd_en in cycle T gives rd_valid=1 and rd_data in cycle T+2.
  - Fully pipelined; one read per cycle sustained.
  - A read of the address written in the same cycle returns the old data.
- Free path: rel_en in cycle T gives free=1 and freeidx=rel_idx in cycle T+1, for exactly one cycle per release.
  - Back-to-back releases produce back-to-back free pulses.
- err: sticky until reset.

Optional Feature:
- CCI_MPF_EDGE_WDATA_HEAP_BYPASS_EN:
  - Defined: a read of the same {idx, clnum} written in cycle T, or in cycle T-1, returns the new wdata. Implemented as forwarding registers matched against the read address; read latency stays 2.
  - Undefined: no forwarding; same-cycle read returns old data. Software must order writes at least 2 cycles before reads.

Decomposition:
- Shared package cci_mpf_shim_edge_pkg:
  - t_heap_idx, t_heap_clnum, t_heap_cnt typedefs.
  - t_wdata_fsm enum {IDLE, IN_PKT}.
  - Heap address concatenation helper.
- One sub-module, cci_mpf_shim_edge_heap_ram: simple dual-port RAM with registered address and registered output (2-cycle read), depth N*N_LINES_PER_ENTRY.

Test Plan:
- Single-line packet: wen, wsop=weop=1, widx=5, wclnum=0, wdata=0xA5..; rd_en idx5/cl0 two cycles later -> rd_valid at T+2 with 0xA5..; count=1.
- 4-line packet: idx 9, wclnum 0..3 on consecutive cycles -> no err. Read cl3 -> data of the 4th line. rel_en idx9 -> free=1, freeidx=9 the next cycle; count returns to 0.
- Fill 120 slots with N=128, thresh=8 -> wAlmFull=1 the cycle after the 120th wsop. One rel_en -> wAlmFull=0 the next cycle. Allocate and release in the same cycle -> count unchanged.
- Overflow: allocate 129 slots -> err=1 after the 129th and count stays 128. Reset_n pulse -> err=0, count=0, wAlmFull=0.
- Protocol violations: wclnum sequence 0,2 -> err=1. Separately, wsop during IN_PKT -> err=1.
- Bypass: write idx3/cl1 data 0x77 and read the same address in the same cycle -> with the macro rd_data=0x77; without it, the old value.
